// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
// multicycle_alu: registered MIPS ALU; single-cycle ops plus iterative mul/div (ops 16-21).
// Latency: 1 cycle for single-cycle ops, WIDTH+2 cycles for every mul/div op.
// Backpressure: busy is high while a mul/div is in flight; start is ignored (not queued) while busy.
// Ports: clk/rst_n (async active-low); start/flush/ctrl/data_in_A/data_in_B in;
//        data_out (registered result), zero (data_out == 0), busy, done (one-cycle pulse) out.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [4:0]       ctrl,
    input  logic [WIDTH-1:0] data_in_A,
    input  logic [WIDTH-1:0] data_in_B,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // CALC spends WIDTH arithmetic steps plus one idle step (count == STEPS)
    // so every iterative op completes exactly WIDTH+2 cycles after acceptance.
    localparam logic [SHW:0] STEPS = (SHW+1)'(WIDTH);

    state_t           state, state_nx;
    logic [SHW:0]     count;
    logic [4:0]       op;
    logic [WIDTH-1:0] acc_hi;     // mul: running high half; div: partial remainder
    logic [WIDTH-1:0] acc_lo;     // mul: multiplier/low half; div: dividend/quotient
    logic [WIDTH-1:0] opnd;       // mul: multiplicand; div: divisor magnitude
    logic [WIDTH-1:0] a_orig;     // dividend as issued, returned as remainder on divide by zero
    logic             a_neg, b_neg, div_zero;

    logic             accept, is_multi, div_sig, is_mul_op;
    logic             load_out;
    logic [WIDTH-1:0] out_nx, alu_res, fix_res, q_sgn, r_sgn;
    logic [SHW-1:0]   shamt;
    logic             shift_big;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    assign busy = (state != IDLE);
    assign zero = (data_out == '0);

    assign accept    = (state == IDLE) && start;
    assign is_multi  = (ctrl >= 5'd16) && (ctrl <= 5'd21);
    assign div_sig   = (ctrl == 5'd20) || (ctrl == 5'd21);
    assign is_mul_op = (op == 5'd16) || (op == 5'd17);

    // Shifts use the whole of A: any amount >= WIDTH saturates.
    assign shamt     = data_in_A[SHW-1:0];
    assign shift_big = |data_in_A[WIDTH-1:SHW];

    always_comb begin
        alu_res = '0;
        case (ctrl)
            5'd0:  alu_res = data_in_A;
            5'd1:  alu_res = data_in_B;
            5'd2:  alu_res = data_in_A + data_in_B;
            5'd3:  alu_res = data_in_A - data_in_B;
            5'd4:  alu_res = data_in_A & data_in_B;
            5'd5:  alu_res = data_in_A | data_in_B;
            5'd6:  alu_res = ~data_in_A;
            5'd7:  alu_res = data_in_A ^ data_in_B;
            5'd8:  alu_res = {{(WIDTH-1){1'b0}}, data_in_A != data_in_B};
            5'd9:  alu_res = shift_big ? '0 : (data_in_B << shamt);
            5'd10: alu_res = shift_big ? '0 : (data_in_B >> shamt);
            5'd11: alu_res = shift_big ? {WIDTH{data_in_B[WIDTH-1]}}
                                       : $unsigned($signed(data_in_B) >>> shamt);
            5'd12: alu_res = {{(WIDTH-1){1'b0}}, data_in_A < data_in_B};
            5'd13: alu_res = {{(WIDTH-1){1'b0}}, $signed(data_in_A) < $signed(data_in_B)};
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply / restoring divide.
    // div_diff[WIDTH] set means the trial subtraction went negative.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // Sign correction and special cases. Signed overflow (min / -1) needs no
    // special path: |min| / 1 gives min with remainder 0 and both signs cancel.
    always_comb begin
        q_sgn   = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
        r_sgn   = a_neg ? -acc_hi : acc_hi;
        fix_res = '0;
        case (op)
            5'd16: fix_res = acc_lo;
            5'd17: fix_res = acc_hi;
            5'd18: fix_res = div_zero ? '1     : acc_lo;
            5'd19: fix_res = div_zero ? a_orig : acc_hi;
            5'd20: fix_res = div_zero ? '1     : q_sgn;
            5'd21: fix_res = div_zero ? a_orig : r_sgn;
            default: fix_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        load_out = 1'b0;
        out_nx   = alu_res;
        case (state)
            IDLE: begin
                // flush has no effect here; a coincident start is accepted
                if (start) begin
                    if (is_multi) begin
                        state_nx = CALC;
                    end else begin
                        load_out = 1'b1;
                        out_nx   = alu_res;
                    end
                end
            end
            CALC: begin
                if (flush)               state_nx = IDLE;
                else if (count == STEPS) state_nx = FIX;
            end
            FIX: begin
                state_nx = IDLE;
                if (!flush) begin
                    load_out = 1'b1;
                    out_nx   = fix_res;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            done     <= 1'b0;
            count    <= '0;
            op       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= load_out;
            if (load_out) data_out <= out_nx;

            if (accept && is_multi) begin
                op       <= ctrl;
                count    <= '0;
                a_orig   <= data_in_A;
                a_neg    <= div_sig && data_in_A[WIDTH-1];
                b_neg    <= div_sig && data_in_B[WIDTH-1];
                div_zero <= (data_in_B == '0);
                acc_hi   <= '0;
                if ((ctrl == 5'd16) || (ctrl == 5'd17)) begin
                    acc_lo <= data_in_B;
                    opnd   <= data_in_A;
                end else begin
                    acc_lo <= (div_sig && data_in_A[WIDTH-1]) ? -data_in_A : data_in_A;
                    opnd   <= (div_sig && data_in_B[WIDTH-1]) ? -data_in_B : data_in_B;
                end
            end else if (state == CALC) begin
                count <= count + 1'b1;
                if (count != STEPS) begin
                    if (is_mul_op) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered ALU for the MIPS datapath. It executes the full single-cycle operation set in one clock and adds iterative multiply and divide (unsigned and signed) over a fixed multi-cycle latency. Operations are issued through a start/busy/done handshake, so the control unit can stall the EX stage while an iterative operation is in flight. The result is held in an output register until the next accepted operation.

## Interface
- WIDTH, 16: operand/result width; ≥4, power of two.
- SHW, $clog2(WIDTH): internal shift-amount width; not overridden.
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  issue request; accepted only when busy=0.
- flush  in  1  synchronous cancel of an in-flight operation.
- ctrl  in  5  operation code, sampled at acceptance.
- data_in_A  in  WIDTH  operand A, sampled at acceptance.
- data_in_B  in  WIDTH  operand B, sampled at acceptance.
- data_out  out  WIDTH  registered result.
- zero  out  1  data_out == 0.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: data_out is valid for the last accepted op.

## Operation
- Opcodes, single-cycle:
  - 0: A. 1: B. 2: A+B. 3: A−B (mod 2^WIDTH). 4: A&B. 5: A|B. 6: ~A. 7: A^B.
  - 8: A!=B → 1/0. 9: B<<A. 10: B>>A logical. 11: B>>>A arithmetic.
  - 12: A<B unsigned → 1/0. 13: A<B signed → 1/0.
- Opcodes, multi-cycle:
  - 16 MULLO: low half of unsigned A×B.
  - 17 MULHI: high half of unsigned A×B.
  - 18 DIVU. 19 REMU. 20 DIV, signed, truncating toward zero. 21 REM, signed; sign follows the dividend.
- All other codes (14, 15, 22–31) are single-cycle and return 0.
- Shifts use the full value of A. If A ≥ WIDTH, the logical result is 0 and the arithmetic result is all copies of B[WIDTH−1].
- Divide by zero: quotient = all ones; remainder = dividend (A). Applies to signed and unsigned.
- Signed overflow (A = most-negative, B = −1): quotient = A, remainder = 0.
- State machine:
  - IDLE, accept (start=1): single-cycle op → compute, load data_out, pulse done, stay IDLE. Multi-cycle op → latch operands and take magnitudes if signed, go CALC with counter = 0.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After WIDTH steps, go FIX.
  - FIX: apply sign correction and the divide-by-zero / overflow rules, load data_out, pulse done, go IDLE.
- busy = 1 in CALC and FIX.
- start while busy is ignored. There is no queueing, and ctrl/operands are not re-sampled.
- flush in CALC or FIX: go IDLE next cycle, no done, data_out unchanged. flush in IDLE has no effect.
- Simultaneous flush and start in IDLE: start is accepted.
- data_out changes only at the cycle where done is asserted.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - data_out = 0, zero = 1, busy = 0, done = 0, state IDLE, counter 0.
  - Reset mid-operation aborts immediately; no done is issued.
- Single-cycle ops: start sampled at edge N; data_out and done valid after edge N. Latency 1, throughput 1 per cycle.
- Multi-cycle ops, fixed latency WIDTH+2 (18 for WIDTH=16):
  - Accepted at edge N; busy rises after edge N.
  - done and data_out valid after edge N+WIDTH+2; busy falls at the same edge.
  - Latency is identical for every multi-cycle opcode and every operand value, including divide by zero.
- A new start may be asserted in the same cycle that done is high and is accepted. Back-to-back issue carries no bubble.
- zero is combinational from the data_out register.

## Test plan
- WIDTH=16, op 2, A=0x7FFF, B=0x0001 → data_out 0x8000, done one cycle later, zero=0. Op 3 with A=B=0x1234 → 0x0000, zero=1.
- Op 16/17, A=B=0xFFFF → MULLO 0x0001, MULHI 0xFFFE. Each: done exactly 18 cycles after start, busy high for those 18 cycles.
- Op 20/21, A=0xFFF9 (−7), B=0x0002 → quotient 0xFFFD, remainder 0xFFFF. A=0x8000, B=0xFFFF → quotient 0x8000, remainder 0x0000.
- Op 18/19, A=0x1234, B=0 → quotient 0xFFFF, remainder 0x1234, latency 18. Shift ops with A=16, B=0x8001 → op 10 gives 0x0000, op 11 gives 0xFFFF.
- Issue op 16, then at cycle 5 assert start with op 2 → ignored, MUL result delivered at cycle 18. Then issue op 18 and flush at cycle 7 → no done, data_out holds prior value, next start accepted.
- Assert rst_n=0 asynchronously mid-DIV → busy, done, data_out clear immediately, zero=1. After release, op 0 with A=0x00AB → 0x00AB in 1 cycle.
